// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: forwarding select encoding and
// the data-memory wait FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  localparam int REG_W = 5;
  localparam int TMO_W = 8;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding decode for the instruction leaving ID.
// A producer in EX wins over one in MEM because it is the younger write.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic             used,
  input  logic [REG_W-1:0] wrt_dst_exe,
  input  logic             reg_wrt_en_exe,
  input  logic             rd_en_exe,
  input  logic [REG_W-1:0] wrt_dst_mem,
  input  logic             reg_wrt_en_mem,
  output fwd_sel_t         sel
);

  always_comb begin
    sel = FWD_REG;
    if (used && rs != '0) begin
      if (rs == wrt_dst_exe && reg_wrt_en_exe && !rd_en_exe) begin
        sel = FWD_MEM;
      end else if (rs == wrt_dst_mem && reg_wrt_en_mem) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: forwarding selects,
// stall/flush strobes, data-memory wait FSM with timeout, and perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1_id,
  input  logic [REG_W-1:0] rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [REG_W-1:0] wrt_dst_exe,
  input  logic             reg_wrt_en_exe,
  input  logic             rd_en_exe,
  input  logic [REG_W-1:0] wrt_dst_mem,
  input  logic             reg_wrt_en_mem,
  input  logic             rd_en_mem,
  input  logic             mem_wrt_en_mem,
  input  logic             mem_ack,
  input  logic             branch,
  output logic [1:0]       forward_control1,
  output logic [1:0]       forward_control2,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             stall_id_ex,
  output logic             flush_id_ex,
  output logic             stall_mem,
  output logic             stall_wb,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output mem_state_t       fsm_state
);

  logic             mem_access;
  logic             mem_wait;
  logic             load_use;
  logic [TMO_W-1:0] tmo_cnt;
  fwd_sel_t         sel1;
  fwd_sel_t         sel2;
  fwd_sel_t         fc1_q;
  fwd_sel_t         fc2_q;

  assign mem_access = rd_en_mem | mem_wrt_en_mem;
  assign mem_wait   = mem_access & ~mem_ack;

  assign load_use = rd_en_exe & reg_wrt_en_exe & (wrt_dst_exe != '0) &
                    ((rs1_used_id & (rs1_id == wrt_dst_exe)) |
                     (rs2_used_id & (rs2_id == wrt_dst_exe)));

  // Priority: memory stall freezes everything (a branch re-presents later),
  // then branch flush, then the one-cycle load-use bubble.
  always_comb begin
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    stall_id_ex = 1'b0;
    flush_id_ex = 1'b0;
    stall_mem   = 1'b0;
    stall_wb    = 1'b0;
    if (mem_wait) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      stall_id_ex = 1'b1;
      stall_mem   = 1'b1;
      stall_wb    = 1'b1;
    end else if (branch) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (load_use) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  hazard_fwd_sel u_fwd1 (
    .rs             (rs1_id),
    .used           (rs1_used_id),
    .wrt_dst_exe    (wrt_dst_exe),
    .reg_wrt_en_exe (reg_wrt_en_exe),
    .rd_en_exe      (rd_en_exe),
    .wrt_dst_mem    (wrt_dst_mem),
    .reg_wrt_en_mem (reg_wrt_en_mem),
    .sel            (sel1)
  );

  hazard_fwd_sel u_fwd2 (
    .rs             (rs2_id),
    .used           (rs2_used_id),
    .wrt_dst_exe    (wrt_dst_exe),
    .reg_wrt_en_exe (reg_wrt_en_exe),
    .rd_en_exe      (rd_en_exe),
    .wrt_dst_mem    (wrt_dst_mem),
    .reg_wrt_en_mem (reg_wrt_en_mem),
    .sel            (sel2)
  );

  // Selects travel with the instruction into EX, so they hold while ID/EX holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      fc1_q     <= FWD_REG;
      fc2_q     <= FWD_REG;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!stall_id_ex) begin
        fc1_q <= flush_id_ex ? FWD_REG : sel1;
        fc2_q <= flush_id_ex ? FWD_REG : sel2;
      end
      if (stall_pc) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_if_id) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign forward_control1 = fc1_q;
  assign forward_control2 = fc2_q;

  // The counter holds once the timeout is reached; mem_err is sticky until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_state <= RUN;
      tmo_cnt   <= '0;
      mem_err   <= 1'b0;
    end else begin
      case (fsm_state)
        RUN: begin
          if (mem_wait) begin
            fsm_state <= MEM_WAIT;
            tmo_cnt   <= TMO_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            fsm_state <= RUN;
          end else if (tmo_cnt >= TMO_W'(MEM_TIMEOUT - 1)) begin
            mem_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: fsm_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: stimulus table, hand-written corner sequences and
// random cycles, all checked against a cycle-level reference model.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int MT = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1_id, rs2_id, wrt_dst_exe, wrt_dst_mem;
  logic          rs1_used_id, rs2_used_id, reg_wrt_en_exe, rd_en_exe;
  logic          reg_wrt_en_mem, rd_en_mem, mem_wrt_en_mem, mem_ack, branch;
  logic [1:0]    forward_control1, forward_control2;
  logic          stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex;
  logic          stall_mem, stall_wb, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  mem_state_t    fsm_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .wrt_dst_exe(wrt_dst_exe), .reg_wrt_en_exe(reg_wrt_en_exe), .rd_en_exe(rd_en_exe),
    .wrt_dst_mem(wrt_dst_mem), .reg_wrt_en_mem(reg_wrt_en_mem), .rd_en_mem(rd_en_mem),
    .mem_wrt_en_mem(mem_wrt_en_mem), .mem_ack(mem_ack), .branch(branch),
    .forward_control1(forward_control1), .forward_control2(forward_control2),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
    .stall_id_ex(stall_id_ex), .flush_id_ex(flush_id_ex),
    .stall_mem(stall_mem), .stall_wb(stall_wb), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .fsm_state(fsm_state)
  );

  typedef struct {
    logic [4:0] rs1, rs2, dex, dmem;
    logic u1, u2, wex, rex, wmem, rmem, smem, ack, br;
  } in_t;

  typedef struct {
    logic mw, spc, sif, fif, sid, fid, smem, swb;
  } cexp_t;

  // Table row: inputs plus expected {stall_pc, stall_if_id, flush_if_id, flush_id_ex, stall_wb}
  typedef struct {
    in_t        v;
    logic [4:0] strb;
  } vec_t;

  // Reference model state
  logic [1:0]    m_fc1, m_fc2;
  logic          m_err;
  logic [CW-1:0] m_stall_cnt, m_flush_cnt;
  bit            m_in_wait;
  int            m_wait_len;

  function automatic in_t mk(input int rs1, rs2, u1, u2, dex, wex, rex,
                             dmem, wmem, rmem, smem, ack, br);
    in_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1[0]; v.u2 = u2[0];
    v.dex = 5'(dex); v.wex = wex[0]; v.rex = rex[0];
    v.dmem = 5'(dmem); v.wmem = wmem[0]; v.rmem = rmem[0]; v.smem = smem[0];
    v.ack = ack[0]; v.br = br[0];
    return v;
  endfunction

  function automatic in_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endfunction

  function automatic cexp_t model_comb(input in_t v);
    cexp_t e;
    logic lu;
    e = '{default: 1'b0};
    e.mw = (v.rmem | v.smem) & !v.ack;
    lu = v.rex && v.wex && v.dex != 0 &&
         ((v.u1 && v.rs1 == v.dex) || (v.u2 && v.rs2 == v.dex));
    if (e.mw) begin
      e.spc = 1; e.sif = 1; e.sid = 1; e.smem = 1; e.swb = 1;
    end else if (v.br) begin
      e.fif = 1; e.fid = 1;
    end else if (lu) begin
      e.spc = 1; e.sif = 1; e.fid = 1;
    end
    return e;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] rs, input logic used, input in_t v);
    if (!used || rs == 0) return 2'b00;
    if (rs == v.dex && v.wex && !v.rex) return 2'b10;
    if (rs == v.dmem && v.wmem) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t v);
    rs1_id = v.rs1; rs2_id = v.rs2; rs1_used_id = v.u1; rs2_used_id = v.u2;
    wrt_dst_exe = v.dex; reg_wrt_en_exe = v.wex; rd_en_exe = v.rex;
    wrt_dst_mem = v.dmem; reg_wrt_en_mem = v.wmem; rd_en_mem = v.rmem;
    mem_wrt_en_mem = v.smem; mem_ack = v.ack; branch = v.br;
  endtask

  task automatic do_reset();
    drive(idle());
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_fc1 = 0; m_fc2 = 0; m_err = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    m_in_wait = 0; m_wait_len = 0;
  endtask

  // One clock cycle: drive, compare everything at the falling edge, advance the model.
  task automatic step(input in_t v, input bit use_tbl, input logic [4:0] strb);
    cexp_t e;
    logic [1:0] n_fc1, n_fc2;
    drive(v);
    @(negedge clk);
    e = model_comb(v);
    check("stall_pc", stall_pc, e.spc);
    check("stall_if_id", stall_if_id, e.sif);
    check("flush_if_id", flush_if_id, e.fif);
    check("stall_id_ex", stall_id_ex, e.sid);
    check("flush_id_ex", flush_id_ex, e.fid);
    check("stall_mem", stall_mem, e.smem);
    check("stall_wb", stall_wb, e.swb);
    check("fwd1", forward_control1, m_fc1);
    check("fwd2", forward_control2, m_fc2);
    check("mem_err", mem_err, m_err);
    check("stall_cnt", stall_cnt, m_stall_cnt);
    check("flush_cnt", flush_cnt, m_flush_cnt);
    check("in_wait", fsm_state == MEM_WAIT, m_in_wait);
    if (use_tbl)
      check("tbl_strobes", {stall_pc, stall_if_id, flush_if_id, flush_id_ex, stall_wb}, strb);
    n_fc1 = m_fc1; n_fc2 = m_fc2;
    if (!e.sid) begin
      n_fc1 = e.fid ? 2'b00 : model_fwd(v.rs1, v.u1, v);
      n_fc2 = e.fid ? 2'b00 : model_fwd(v.rs2, v.u2, v);
    end
    @(posedge clk); #1;
    m_fc1 = n_fc1; m_fc2 = n_fc2;
    m_stall_cnt += CW'(e.spc);
    m_flush_cnt += CW'(e.fif);
    if (!m_in_wait) begin
      if (e.mw) begin m_in_wait = 1; m_wait_len = 1; end
    end else if (v.ack) begin
      m_in_wait = 0;
    end else begin
      m_wait_len++;
    end
    if (m_in_wait && m_wait_len >= MT) m_err = 1;
  endtask

  task automatic run(input in_t v);
    step(v, 1'b0, 5'b0);
  endtask

  vec_t tbl[10];
  in_t  r;

  initial begin
    tbl[0] = '{idle(), 5'b00000};
    tbl[1] = '{mk(1, 2, 1, 1, 3, 1, 0, 4, 1, 1, 0, 0, 0), 5'b11001};  // load waits
    tbl[2] = '{mk(1, 2, 1, 1, 3, 1, 0, 4, 1, 0, 1, 0, 1), 5'b11001};  // store wait beats branch
    tbl[3] = '{mk(1, 2, 1, 1, 3, 1, 0, 4, 1, 1, 0, 1, 0), 5'b00000};  // ack cycle
    tbl[4] = '{mk(7, 2, 1, 1, 7, 1, 1, 0, 0, 0, 0, 1, 0), 5'b11010};  // load-use rs1
    tbl[5] = '{mk(1, 7, 0, 1, 7, 1, 1, 0, 0, 0, 0, 1, 0), 5'b11010};  // load-use rs2
    tbl[6] = '{mk(7, 7, 0, 0, 7, 1, 1, 0, 0, 0, 0, 1, 0), 5'b00000};  // operands unused
    tbl[7] = '{mk(7, 2, 1, 1, 7, 0, 1, 0, 0, 0, 0, 1, 0), 5'b00000};  // load not writing
    tbl[8] = '{mk(7, 2, 1, 1, 7, 1, 1, 0, 0, 0, 0, 1, 1), 5'b00110};  // branch beats load-use
    tbl[9] = '{mk(0, 0, 1, 1, 0, 1, 1, 0, 1, 0, 0, 1, 0), 5'b00000};  // x0 load

    do_reset();
    check("rst_fwd1", forward_control1, 2'b00);
    check("rst_fwd2", forward_control2, 2'b00);
    check("rst_err", mem_err, 1'b0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    check("rst_state", fsm_state == RUN, 1'b1);

    foreach (tbl[i]) step(tbl[i].v, 1'b1, tbl[i].strb);

    // add x5 ; add x6,x5,x1 -> EX forward; then one instruction apart -> WB forward
    do_reset();
    run(mk(5, 1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 1, 0));
    check("seq_fwd_ex", forward_control1, 2'b10);
    check("seq_fwd_ex_b", forward_control2, 2'b00);
    run(mk(5, 1, 1, 1, 9, 1, 0, 5, 1, 0, 0, 1, 0));
    check("seq_fwd_wb", forward_control1, 2'b01);
    check("seq_no_stall", stall_cnt, 0);

    // lw x7 ; add x8,x7,x7
    do_reset();
    run(mk(7, 7, 1, 1, 7, 1, 1, 0, 0, 0, 0, 1, 0));
    check("lu_bubble_fwd", forward_control1, 2'b00);
    run(mk(7, 7, 1, 1, 0, 0, 0, 7, 1, 1, 0, 1, 0));
    check("lu_fwd1", forward_control1, 2'b01);
    check("lu_fwd2", forward_control2, 2'b01);
    check("lu_stall_cnt", stall_cnt, 1);

    // taken branch with load-use in ID
    do_reset();
    run(mk(7, 2, 1, 1, 7, 1, 1, 0, 0, 0, 0, 1, 1));
    check("br_flush_cnt", flush_cnt, 1);
    check("br_stall_cnt", stall_cnt, 0);

    // load in MEM, 3 wait cycles then ack
    do_reset();
    repeat (3) run(mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0));
    check("wait_state", fsm_state == MEM_WAIT, 1'b1);
    run(mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 1, 0, 1, 0));
    check("wait_back_run", fsm_state == RUN, 1'b1);
    check("wait_stall_cnt", stall_cnt, 3);
    check("wait_no_err", mem_err, 1'b0);

    // timeout with mem_ack held low
    do_reset();
    repeat (3) run(mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0));
    check("tmo_not_yet", mem_err, 1'b0);
    run(mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0));
    check("tmo_err", mem_err, 1'b1);
    run(mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 1, 0, 1, 0));
    check("tmo_sticky", mem_err, 1'b1);
    do_reset();
    check("tmo_rst_err", mem_err, 1'b0);
    check("tmo_rst_cnt", stall_cnt, 0);

    // write to x0 then reader of x0
    run(mk(0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0));
    check("x0_fwd1", forward_control1, 2'b00);
    check("x0_fwd2", forward_control2, 2'b00);
    check("x0_no_stall", stall_cnt, 0);

    // random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) do_reset();
      r.rs1 = 5'($urandom_range(0, 3)); r.rs2 = 5'($urandom_range(0, 3));
      r.dex = 5'($urandom_range(0, 3)); r.dmem = 5'($urandom_range(0, 3));
      r.u1 = 1'($urandom); r.u2 = 1'($urandom);
      r.wex = 1'($urandom); r.rex = 1'($urandom); r.wmem = 1'($urandom);
      r.rmem = ($urandom_range(0, 3) == 0); r.smem = ($urandom_range(0, 3) == 0);
      r.ack = ($urandom_range(0, 9) < 7); r.br = ($urandom_range(0, 4) == 0);
      run(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
